// File: rtl/fifo_8x8.sv
// fifo_8x8: single-clock synchronous FIFO, DEPTH entries of DATA_WIDTH bits.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   reset     - synchronous active-high reset (pointers, count, data_out)
//   write_en  - push request, accepted when not full
//   read_en   - pop request, accepted when not empty
//   data_in   - push data
//   data_out  - registered pop data, holds its value when no pop is accepted
//   empty     - occupancy is 0
//   full      - occupancy is DEPTH
//
// The write in "simultaneous push/pop while empty" is not forwarded to
// data_out; the new entry becomes poppable on the following edge.

module fifo_8x8 #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  push;
    logic                  pop;

    // Flags decode the registered count only, so no input reaches an output.
    assign empty = (count == '0);
    assign full  = (count == (ADDR_WIDTH + 1)'(DEPTH));

    assign push = write_en && !full;
    assign pop  = read_en && !empty;

    // Storage is not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            if (push) begin
                // Pointer width equals log2(DEPTH), so the add wraps naturally.
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (ADDR_WIDTH + 1)'(1);
                2'b01:   count <= count - (ADDR_WIDTH + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_8x8.sv
// tb_fifo_8x8: self-checking bench for fifo_8x8.
// A queue model tracks stored entries; each accepted pop pushes its expected
// byte onto a scoreboard queue that is popped and compared after the edge.

module tb_fifo_8x8;

    logic       clk;
    logic       reset;
    logic       write_en;
    logic       read_en;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       empty;
    logic       full;

    int n_cmp;
    int n_err;

    logic [7:0] model_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] last_out;

    fifo_8x8 dut (
        .clk      (clk),
        .reset    (reset),
        .write_en (write_en),
        .read_en  (read_en),
        .data_in  (data_in),
        .data_out (data_out),
        .empty    (empty),
        .full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock with the given inputs; model and scoreboard update, then check.
    task automatic cycle(input logic we, input logic re, input logic [7:0] din);
        logic do_push;
        logic do_pop;
        logic popped;
        write_en = we;
        read_en  = re;
        data_in  = din;
        do_pop   = re && (model_q.size() != 0);
        do_push  = we && (model_q.size() != 8);
        if (do_pop) exp_q.push_back(model_q.pop_front());
        if (do_push) model_q.push_back(din);
        @(posedge clk);
        #1;
        popped = 1'b0;
        if (exp_q.size() != 0) begin
            last_out = exp_q.pop_front();
            popped   = 1'b1;
        end
        check_eq(popped ? "data_out" : "data_hold", {24'h0, data_out}, {24'h0, last_out});
        check_eq("empty", {31'h0, empty}, {31'h0, model_q.size() == 0});
        check_eq("full", {31'h0, full}, {31'h0, model_q.size() == 8});
    endtask

    task automatic do_reset(input logic we);
        reset    = 1'b1;
        write_en = we;
        read_en  = 1'b0;
        data_in  = 8'hEE;
        @(posedge clk);
        #1;
        reset = 1'b0;
        write_en = 1'b0;
        model_q.delete();
        exp_q.delete();
        last_out = 8'h00;
        check_eq("rst_empty", {31'h0, empty}, 32'd1);
        check_eq("rst_full", {31'h0, full}, 32'd0);
        check_eq("rst_data", {24'h0, data_out}, 32'h00);
    endtask

    initial begin
        logic [7:0] fill_data [8];
        fill_data = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hFF};
        n_cmp    = 0;
        n_err    = 0;
        last_out = 8'h00;
        reset    = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        data_in  = 8'h00;
        #2;

        // 1. Reset
        do_reset(1'b0);

        // 2. Fill, then overflow attempt
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, fill_data[i]);
        check_eq("fill_full", {31'h0, full}, 32'd1);
        cycle(1'b1, 1'b0, 8'h55);

        // 3. Partial drain
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h00);
        check_eq("drain5_data", {24'h0, data_out}, 32'h9A);

        // 4. Drain to empty, then underflow
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00);
        check_eq("drain_last", {24'h0, data_out}, 32'hFF);
        cycle(1'b0, 1'b1, 8'h00);
        check_eq("underflow_hold", {24'h0, data_out}, 32'hFF);

        // 5. Wrap with simultaneous access at occupancy 4
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h20 + 8'(i));
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 8'h30 + 8'(i));
        check_eq("wrap_data", {24'h0, data_out}, 32'h35);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h00);
        check_eq("wrap_tail", {24'h0, data_out}, 32'h39);
        // Push and pop together while empty: only the push is taken.
        cycle(1'b1, 1'b1, 8'h77);
        check_eq("simul_empty_hold", {24'h0, data_out}, 32'h39);
        cycle(1'b0, 1'b1, 8'h00);
        check_eq("simul_empty_pop", {24'h0, data_out}, 32'h77);

        // Random traffic against the model
        for (int i = 0; i < 200; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        end

        // 6. Mid-operation reset with write_en high
        while (model_q.size() != 0) cycle(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h60 + 8'(i));
        do_reset(1'b1);
        cycle(1'b1, 1'b0, 8'hA5);
        cycle(1'b0, 1'b1, 8'h00);
        check_eq("post_rst_data", {24'h0, data_out}, 32'hA5);
        cycle(1'b0, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
